rs_age_sel: RTL and testbench

Parametrised reservation station for the out-of-order core: holds up to `RS_SZ` dispatched instructions, tracks source-operand readiness by physical tag, wakes operands from `CDB_N` parallel result broadcasts, and issues one ready instruction per cycle with oldest-first priority. It sits between dispatch (rename/decode) and the functional-unit issue stage. It supersedes the single-CDB, index-removal RS: selection is internal and age-ordered, issue uses a valid/ready handshake, and the block supports a pipeline flush.

---
 rtl/rs_age_sel.sv | 150 +++++++++++++++
 tb/tb_rs_age_sel.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_age_sel.sv
// Reservation station with CDB wakeup, dispatch bypass and oldest-first issue.
// Entries carry an age rank; the issuable entry with the highest rank is presented.
module rs_age_sel #(
  parameter int RS_SZ     = 8,
  parameter int TAG_W     = 6,
  parameter int PAYLOAD_W = 64,
  parameter int CDB_N     = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [CDB_N-1:0]           cdb_valid,
  input  logic [CDB_N*TAG_W-1:0]     cdb_tag,
  input  logic                       in_en,
  input  logic [TAG_W-1:0]           in_src1_tag,
  input  logic [TAG_W-1:0]           in_src2_tag,
  input  logic                       in_src1_rdy,
  input  logic                       in_src2_rdy,
  input  logic [TAG_W-1:0]           in_dest_tag,
  input  logic [PAYLOAD_W-1:0]       in_payload,
  output logic                       issue_valid,
  input  logic                       issue_ready,
  output logic [TAG_W-1:0]           issue_dest_tag,
  output logic [PAYLOAD_W-1:0]       issue_payload,
  output logic                       full,
  output logic [$clog2(RS_SZ):0]     free_cnt
);

  localparam int IDX_W = $clog2(RS_SZ);
  localparam int CNT_W = IDX_W + 1;

  logic [RS_SZ-1:0]     valid;
  logic [RS_SZ-1:0]     src1_rdy;
  logic [RS_SZ-1:0]     src2_rdy;
  logic [TAG_W-1:0]     src1_tag [RS_SZ];
  logic [TAG_W-1:0]     src2_tag [RS_SZ];
  logic [TAG_W-1:0]     dest_tag [RS_SZ];
  logic [PAYLOAD_W-1:0] payload  [RS_SZ];
  logic [IDX_W-1:0]     age      [RS_SZ];

  logic [RS_SZ-1:0] wake1, wake2;
  logic             byp1, byp2;
  logic [CNT_W-1:0] free_cnt_c;
  logic [IDX_W-1:0] free_idx;
  logic             free_found;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] sel_age;
  logic             sel_any;
  logic             fire;
  logic             disp;

  function automatic logic cdb_hit(input logic [TAG_W-1:0]       t,
                                   input logic [CDB_N-1:0]       v,
                                   input logic [CDB_N*TAG_W-1:0] tags);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < CDB_N; k++)
      if (v[k] && tags[k*TAG_W +: TAG_W] == t) hit = 1'b1;
    return hit;
  endfunction

  always_comb begin
    wake1 = '0;
    wake2 = '0;
    for (int i = 0; i < RS_SZ; i++) begin
      wake1[i] = cdb_hit(src1_tag[i], cdb_valid, cdb_tag);
      wake2[i] = cdb_hit(src2_tag[i], cdb_valid, cdb_tag);
    end
    byp1 = in_src1_rdy || cdb_hit(in_src1_tag, cdb_valid, cdb_tag);
    byp2 = in_src2_rdy || cdb_hit(in_src2_tag, cdb_valid, cdb_tag);
  end

  always_comb begin
    free_cnt_c = '0;
    free_idx   = '0;
    free_found = 1'b0;
    for (int i = 0; i < RS_SZ; i++) begin
      if (!valid[i]) begin
        free_cnt_c = free_cnt_c + CNT_W'(1);
        if (!free_found) begin
          free_idx   = IDX_W'(i);
          free_found = 1'b1;
        end
      end
    end
  end

  // Ages of valid entries are unique, so a strict compare picks exactly one.
  always_comb begin
    sel_idx = '0;
    sel_age = '0;
    sel_any = 1'b0;
    for (int i = 0; i < RS_SZ; i++) begin
      if (valid[i] && src1_rdy[i] && src2_rdy[i] && (!sel_any || age[i] > sel_age)) begin
        sel_idx = IDX_W'(i);
        sel_age = age[i];
        sel_any = 1'b1;
      end
    end
  end

  assign free_cnt       = free_cnt_c;
  assign full           = (free_cnt_c == '0);
  assign issue_valid    = sel_any;
  assign issue_dest_tag = dest_tag[sel_idx];
  assign issue_payload  = payload[sel_idx];
  assign fire           = sel_any && issue_ready;
  assign disp           = in_en && !full && !flush;

  // Age is kept as the rank among valid entries: entries older than the issued
  // one close the gap, so ranks stay below RS_SZ no matter how long one waits.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid    <= '0;
      src1_rdy <= '0;
      src2_rdy <= '0;
      for (int i = 0; i < RS_SZ; i++) begin
        src1_tag[i] <= '0;
        src2_tag[i] <= '0;
        dest_tag[i] <= '0;
        payload[i]  <= '0;
        age[i]      <= '0;
      end
    end else begin
      for (int i = 0; i < RS_SZ; i++) begin
        if (flush) begin
          valid[i] <= 1'b0;
        end else if (disp && free_idx == IDX_W'(i)) begin
          valid[i]    <= 1'b1;
          src1_tag[i] <= in_src1_tag;
          src2_tag[i] <= in_src2_tag;
          src1_rdy[i] <= byp1;
          src2_rdy[i] <= byp2;
          dest_tag[i] <= in_dest_tag;
          payload[i]  <= in_payload;
          age[i]      <= '0;
        end else if (valid[i]) begin
          if (fire && sel_idx == IDX_W'(i)) begin
            valid[i] <= 1'b0;
          end else begin
            if (wake1[i]) src1_rdy[i] <= 1'b1;
            if (wake2[i]) src2_rdy[i] <= 1'b1;
            age[i] <= age[i] + IDX_W'(disp) - IDX_W'(fire && (age[i] > sel_age));
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rs_age_sel.sv
// Bench for rs_age_sel: queue-based oldest-first model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_rs_age_sel;

  localparam int RS_SZ     = 8;
  localparam int TAG_W     = 6;
  localparam int PAYLOAD_W = 64;
  localparam int CDB_N     = 2;

  logic                   clock = 1'b0;
  logic                   reset;
  logic                   flush;
  logic [CDB_N-1:0]       cdb_valid;
  logic [CDB_N*TAG_W-1:0] cdb_tag;
  logic                   in_en;
  logic [TAG_W-1:0]       in_src1_tag, in_src2_tag, in_dest_tag;
  logic                   in_src1_rdy, in_src2_rdy;
  logic [PAYLOAD_W-1:0]   in_payload;
  logic                   issue_valid;
  logic                   issue_ready;
  logic [TAG_W-1:0]       issue_dest_tag;
  logic [PAYLOAD_W-1:0]   issue_payload;
  logic                   full;
  logic [$clog2(RS_SZ):0] free_cnt;

  rs_age_sel #(.RS_SZ(RS_SZ), .TAG_W(TAG_W), .PAYLOAD_W(PAYLOAD_W), .CDB_N(CDB_N)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .in_en(in_en), .in_src1_tag(in_src1_tag), .in_src2_tag(in_src2_tag),
    .in_src1_rdy(in_src1_rdy), .in_src2_rdy(in_src2_rdy),
    .in_dest_tag(in_dest_tag), .in_payload(in_payload),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_dest_tag(issue_dest_tag), .issue_payload(issue_payload),
    .full(full), .free_cnt(free_cnt)
  );

  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: entries in dispatch order, oldest at the front.
  typedef struct {
    logic [TAG_W-1:0]     t1, t2, dest;
    bit                   r1, r2;
    logic [PAYLOAD_W-1:0] pl;
  } ent_t;
  ent_t q[$];

  function automatic bit bus_hit(input logic [TAG_W-1:0] t);
    for (int k = 0; k < CDB_N; k++)
      if (cdb_valid[k] && cdb_tag[k*TAG_W +: TAG_W] == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int model_sel();
    for (int i = 0; i < q.size(); i++)
      if (q[i].r1 && q[i].r2) return i;
    return -1;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      q.delete();
    end else begin
      int   s;
      bit   fire, disp;
      ent_t e;
      s    = model_sel();
      fire = (s >= 0) && issue_ready;
      disp = in_en && (q.size() < RS_SZ) && !flush;
      if (flush) begin
        q.delete();
      end else begin
        if (fire) q.delete(s);
        for (int i = 0; i < q.size(); i++) begin
          e = q[i];
          if (bus_hit(e.t1)) e.r1 = 1'b1;
          if (bus_hit(e.t2)) e.r2 = 1'b1;
          q[i] = e;
        end
        if (disp) begin
          e.t1   = in_src1_tag;
          e.t2   = in_src2_tag;
          e.r1   = in_src1_rdy || bus_hit(in_src1_tag);
          e.r2   = in_src2_rdy || bus_hit(in_src2_tag);
          e.dest = in_dest_tag;
          e.pl   = in_payload;
          q.push_back(e);
        end
      end
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      int s;
      s = model_sel();
      chk("m_issue_valid", 64'(issue_valid), 64'(s >= 0));
      chk("m_full", 64'(full), 64'(q.size() == RS_SZ));
      chk("m_free_cnt", 64'(free_cnt), 64'(RS_SZ - q.size()));
      if (s >= 0) begin
        chk("m_dest", 64'(issue_dest_tag), 64'(q[s].dest));
        chk("m_payload", issue_payload, q[s].pl);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    in_en = 1'b0; flush = 1'b0; cdb_valid = '0; cdb_tag = '0;
    in_src1_tag = '0; in_src2_tag = '0; in_src1_rdy = 1'b0; in_src2_rdy = 1'b0;
    in_dest_tag = '0; in_payload = '0;
  endtask

  task automatic put(input int dest, input int t1, input bit r1, input int t2, input bit r2);
    in_en       = 1'b1;
    in_dest_tag = TAG_W'(dest);
    in_src1_tag = TAG_W'(t1);
    in_src1_rdy = r1;
    in_src2_tag = TAG_W'(t2);
    in_src2_rdy = r2;
    in_payload  = {32'hA5A5_0000 | 32'(dest), $urandom};
  endtask

  initial begin
    reset = 1'b1;
    issue_ready = 1'b0;
    idle();
    #12;
    chk("rst_free_cnt", 64'(free_cnt), 64'd8);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_issue_valid", 64'(issue_valid), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    step();

    // in-order issue, one cycle after dispatch
    issue_ready = 1'b1;
    put(5, 0, 1, 0, 1);  step();
    chk("ord_v5", 64'(issue_valid), 64'd1);
    chk("ord_d5", 64'(issue_dest_tag), 64'd5);
    put(10, 0, 1, 0, 1); step();
    chk("ord_d10", 64'(issue_dest_tag), 64'd10);
    put(15, 0, 1, 0, 1); step();
    chk("ord_d15", 64'(issue_dest_tag), 64'd15);
    in_en = 1'b0;        step();
    chk("ord_empty", 64'(issue_valid), 64'd0);
    chk("ord_free", 64'(free_cnt), 64'd8);

    // CDB wakeup on channel 1
    put(7, 20, 0, 0, 1); step();
    in_en = 1'b0;
    chk("wake_wait", 64'(issue_valid), 64'd0);
    chk("wake_free", 64'(free_cnt), 64'd7);
    cdb_valid = 2'b10;
    cdb_tag   = {6'd20, 6'd0};
    step();
    cdb_valid = '0;
    chk("wake_v", 64'(issue_valid), 64'd1);
    chk("wake_d7", 64'(issue_dest_tag), 64'd7);
    step();
    chk("wake_gone", 64'(issue_valid), 64'd0);

    // dispatch bypass from channel 0
    put(9, 0, 1, 33, 0);
    cdb_valid = 2'b01;
    cdb_tag   = {6'd0, 6'd33};
    step();
    idle();
    chk("byp_v", 64'(issue_valid), 64'd1);
    chk("byp_d9", 64'(issue_dest_tag), 64'd9);
    step();

    // fill, reject while full despite concurrent handshake
    issue_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      put(i, 0, 1, 0, 1);
      step();
    end
    in_en = 1'b0;
    chk("full_flag", 64'(full), 64'd1);
    chk("full_free", 64'(free_cnt), 64'd0);
    chk("full_oldest", 64'(issue_dest_tag), 64'd1);
    put(63, 0, 1, 0, 1);
    issue_ready = 1'b1;
    step();
    in_en = 1'b0;
    issue_ready = 1'b0;
    chk("rej_free", 64'(free_cnt), 64'd1);
    chk("rej_full", 64'(full), 64'd0);
    chk("rej_next", 64'(issue_dest_tag), 64'd2);
    issue_ready = 1'b1;
    repeat (7) step();
    chk("drain_free", 64'(free_cnt), 64'd8);
    chk("drain_empty", 64'(issue_valid), 64'd0);

    // age priority with ready held low, then flush
    issue_ready = 1'b0;
    put(11, 50, 0, 0, 1); step();
    put(12, 51, 0, 0, 1); step();
    put(13, 52, 0, 0, 1); step();
    put(14, 0, 1, 0, 1);  step();
    in_en = 1'b0;
    chk("age_newest", 64'(issue_dest_tag), 64'd14);
    cdb_valid = 2'b01;
    cdb_tag   = {6'd0, 6'd50};
    step();
    cdb_valid = '0;
    chk("age_switch", 64'(issue_dest_tag), 64'd11);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_free", 64'(free_cnt), 64'd8);
    chk("flush_empty", 64'(issue_valid), 64'd0);

    // asynchronous reset with three live entries
    put(21, 0, 1, 0, 1); step();
    put(22, 0, 1, 0, 1); step();
    put(23, 0, 1, 0, 1); step();
    in_en = 1'b0;
    chk("pre_rst_free", 64'(free_cnt), 64'd5);
    chk("pre_rst_d21", 64'(issue_dest_tag), 64'd21);
    #2 reset = 1'b1;
    #1;
    chk("arst_free", 64'(free_cnt), 64'd8);
    chk("arst_full", 64'(full), 64'd0);
    chk("arst_valid", 64'(issue_valid), 64'd0);
    chk("arst_dest", 64'(issue_dest_tag), 64'd0);
    chk("arst_payload", issue_payload, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    step();

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      in_en       = ($urandom_range(0, 99) < 55);
      in_dest_tag = TAG_W'($urandom);
      in_src1_tag = TAG_W'($urandom_range(0, 7));
      in_src2_tag = TAG_W'($urandom_range(0, 7));
      in_src1_rdy = ($urandom_range(0, 99) < 35);
      in_src2_rdy = ($urandom_range(0, 99) < 35);
      in_payload  = {$urandom, $urandom};
      cdb_valid   = CDB_N'($urandom);
      for (int k = 0; k < CDB_N; k++)
        cdb_tag[k*TAG_W +: TAG_W] = TAG_W'($urandom_range(0, 7));
      issue_ready = ($urandom_range(0, 99) < 55);
      flush       = ($urandom_range(0, 99) < 2);
      step();
    end
    idle();
    issue_ready = 1'b0;
    step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
